dispatch_stage: RTL and testbench



---
 rtl/dispatch_stage_pkg.sv | 40 ++++
 rtl/dispatch_stage_wb_slot_reserver.sv | 33 +++
 rtl/dispatch_stage.sv | 97 +++++++++
 tb/tb_dispatch_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dispatch_stage_pkg.sv
// Shared types and defaults for the dispatch stage: execution-unit classes,
// the scheduler entry format and the default unit latencies.
package dispatch_stage_pkg;

    localparam int DEFAULT_ALU_LATENCY = 1;
    localparam int DEFAULT_MUL_LATENCY = 3;
    localparam int DEFAULT_DIV_LATENCY = 12;
    localparam int DEFAULT_WB_DEPTH    = 16;

    typedef enum logic [1:0] {
        EXEC_ALU = 2'd0,
        EXEC_MUL = 2'd1,
        EXEC_DIV = 2'd2
    } exec_class_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [4:0] rd;
        logic [5:0] tag;
    } scheduler_entry_t;

    // The top two opcode bits select the execution unit.
    localparam logic [1:0] OPGRP_MUL = 2'b01;
    localparam logic [1:0] OPGRP_DIV = 2'b10;

    function automatic exec_class_t exec_class_of(input scheduler_entry_t entry);
        case (entry.opcode[3:2])
            OPGRP_MUL: return EXEC_MUL;
            OPGRP_DIV: return EXEC_DIV;
            default:   return EXEC_ALU;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dispatch_stage_wb_slot_reserver.sv
// Writeback-bus reservation shift vector: bit d-1 means the bus is claimed
// d cycles from now. Offers a conflict check and a reserve port by latency.
module wb_slot_reserver #(
    parameter int DEPTH = 16,
    parameter int LAT_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [LAT_W-1:0] check_lat,
    output logic             conflict,
    input  logic             reserve,
    input  logic [LAT_W-1:0] reserve_lat,
    output logic [DEPTH-1:0] reserved
);

    logic [DEPTH-1:0] slot_mask;

    // An op issued now with latency L writes back L+1 cycles out, i.e. bit L.
    assign conflict  = reserved[check_lat];
    assign slot_mask = (DEPTH'(1) << reserve_lat) >> 1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always_ff blocks run in.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            reserved <= '0;
        end else begin
            reserved <= (reserved >> 1) | (reserve ? slot_mask : '0);
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: resolves writeback-slot and divider hazards on the queue's
// offered entry, accepts it combinationally and registers it for execution.
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter int ALU_LATENCY = DEFAULT_ALU_LATENCY,
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY,
    parameter int WB_DEPTH    = DEFAULT_WB_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic                i_want_to_execute,
    input  scheduler_entry_t    i_next_to_execute,
    output logic                o_take,
    output logic                o_ex_valid,
    output scheduler_entry_t    o_ex_entry,
    output exec_class_t         o_ex_class,
    output logic                o_div_busy,
    output logic [WB_DEPTH-1:0] o_wb_reserved
);

    localparam int LAT_W = $clog2(WB_DEPTH);
    localparam int DIV_W = $clog2(DIV_LATENCY + 1);

    if (WB_DEPTH < max3(ALU_LATENCY, MUL_LATENCY, DIV_LATENCY) + 1) begin : g_bad_wb_depth
        $error("dispatch_stage: WB_DEPTH must be at least the longest unit latency plus one");
    end

    exec_class_t      cls;
    logic [LAT_W-1:0] lat;
    logic             wb_conflict;
    logic             div_blocked;
    logic [DIV_W-1:0] div_cnt;

    assign cls = exec_class_of(i_next_to_execute);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lat = LAT_W'(ALU_LATENCY);
        case (cls)
            EXEC_MUL: lat = LAT_W'(MUL_LATENCY);
            EXEC_DIV: lat = LAT_W'(DIV_LATENCY);
            default:  lat = LAT_W'(ALU_LATENCY);
        endcase
    end

    assign div_blocked = (cls == EXEC_DIV) && (div_cnt != '0);
    assign o_take      = i_want_to_execute && !i_flush && !rst && !wb_conflict && !div_blocked;

    wb_slot_reserver #(
        .DEPTH(WB_DEPTH),
        .LAT_W(LAT_W)
    ) u_wb_slots (
        .clk        (clk),
        .rst        (rst),
        .clear      (i_flush),
        .check_lat  (lat),
        .conflict   (wb_conflict),
        .reserve    (o_take),
        .reserve_lat(lat),
        .reserved   (o_wb_reserved)
    );

    // NOTE: the entry payload is reset as well as the valid bit, so a
    // post-reset o_ex_entry is a defined zero rather than stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ex_valid <= 1'b0;
            o_ex_entry <= '0;
            o_ex_class <= EXEC_ALU;
        end else begin
            o_ex_valid <= o_take;
            if (o_take) begin
                o_ex_entry <= i_next_to_execute;
                o_ex_class <= cls;
            end
        end
    end

    // Counter covers the divider's busy window after the cycle it sits in
    // the execute register.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            div_cnt <= '0;
        end else if (o_take && cls == EXEC_DIV) begin
            div_cnt <= DIV_W'(DIV_LATENCY - 1);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign o_div_busy = (div_cnt != '0) || (o_ex_valid && o_ex_class == EXEC_DIV);

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: hand-computed expectations for reset,
// ALU streaming, MUL writeback-slot conflict, divider blocking, flush and reset.
module tb_dispatch_stage;
    import dispatch_stage_pkg::*;

    localparam logic [3:0] OP_ALU = 4'h0;
    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_DIV = 4'h8;

    logic             clk;
    logic             rst;
    logic             i_flush;
    logic             i_want_to_execute;
    scheduler_entry_t i_next_to_execute;
    logic             o_take;
    logic             o_ex_valid;
    scheduler_entry_t o_ex_entry;
    exec_class_t      o_ex_class;
    logic             o_div_busy;
    logic [15:0]      o_wb_reserved;

    int compared;
    int mismatched;

    dispatch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .i_flush          (i_flush),
        .i_want_to_execute(i_want_to_execute),
        .i_next_to_execute(i_next_to_execute),
        .o_take           (o_take),
        .o_ex_valid       (o_ex_valid),
        .o_ex_entry       (o_ex_entry),
        .o_ex_class       (o_ex_class),
        .o_div_busy       (o_div_busy),
        .o_wb_reserved    (o_wb_reserved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic scheduler_entry_t mk(input logic [3:0] op, input logic [5:0] tag);
        scheduler_entry_t e;
        e.opcode = op;
        e.rd     = tag[4:0];
        e.tag    = tag;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic offer(input logic [3:0] op, input logic [5:0] tag);
        i_want_to_execute = 1'b1;
        i_next_to_execute = mk(op, tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ex_valid"}, 32'(o_ex_valid), 32'd0);
        check({tag, "_ex_entry"}, 32'(o_ex_entry), 32'd0);
        check({tag, "_ex_class"}, 32'(o_ex_class), 32'(EXEC_ALU));
        check({tag, "_wb_res"},   32'(o_wb_reserved), 32'd0);
        check({tag, "_div_busy"}, 32'(o_div_busy), 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset with an offer present: nothing may be taken.
        rst = 1'b1;
        i_flush = 1'b0;
        offer(OP_DIV, 6'h3f);
        #1 check("take_during_reset", 32'(o_take), 32'd0);
        @(negedge clk);
        check_reset_state("reset");
        @(negedge clk);

        // ALU stream: taken every cycle, slot 1 reserved after each take.
        rst = 1'b0;
        offer(OP_ALU, 6'd1);
        #1 check("alu1_take", 32'(o_take), 32'd1);
        @(negedge clk);
        check("alu1_ex_valid", 32'(o_ex_valid), 32'd1);
        check("alu1_ex_entry", 32'(o_ex_entry), 32'(mk(OP_ALU, 6'd1)));
        check("alu1_ex_class", 32'(o_ex_class), 32'(EXEC_ALU));
        check("alu1_wb_res", 32'(o_wb_reserved), 32'h0001);
        offer(OP_ALU, 6'd2);
        #1 check("alu2_take", 32'(o_take), 32'd1);
        @(negedge clk);
        check("alu2_ex_entry", 32'(o_ex_entry), 32'(mk(OP_ALU, 6'd2)));
        check("alu2_wb_res", 32'(o_wb_reserved), 32'h0001);

        // MUL reserves distance 3; an ALU two cycles later collides on it.
        offer(OP_MUL, 6'd3);
        #1 check("mul_take", 32'(o_take), 32'd1);
        @(negedge clk);
        check("mul_ex_class", 32'(o_ex_class), 32'(EXEC_MUL));
        check("mul_ex_entry", 32'(o_ex_entry), 32'(mk(OP_MUL, 6'd3)));
        check("mul_wb_res", 32'(o_wb_reserved), 32'h0004);
        i_want_to_execute = 1'b0;
        #1 check("idle_take", 32'(o_take), 32'd0);
        @(negedge clk);
        check("gap_ex_valid", 32'(o_ex_valid), 32'd0);
        check("gap_wb_res", 32'(o_wb_reserved), 32'h0002);
        offer(OP_ALU, 6'd4);
        #1 check("alu_slot_conflict", 32'(o_take), 32'd0);
        @(negedge clk);
        check("alu_retry_wb_res", 32'(o_wb_reserved), 32'h0001);
        #1 check("alu_retry_take", 32'(o_take), 32'd1);
        @(negedge clk);
        check("alu4_ex_valid", 32'(o_ex_valid), 32'd1);
        check("alu4_ex_entry", 32'(o_ex_entry), 32'(mk(OP_ALU, 6'd4)));
        check("alu4_wb_res", 32'(o_wb_reserved), 32'h0001);
        i_want_to_execute = 1'b0;
        #1 check("drain_take", 32'(o_take), 32'd0);
        @(negedge clk);
        check("drain_ex_valid", 32'(o_ex_valid), 32'd0);
        check("drain_wb_res", 32'(o_wb_reserved), 32'h0000);

        // DIV: a second DIV waits exactly DIV_LATENCY cycles.
        offer(OP_DIV, 6'd5);
        #1 check("div1_take", 32'(o_take), 32'd1);
        @(negedge clk);
        check("div1_ex_class", 32'(o_ex_class), 32'(EXEC_DIV));
        check("div1_busy", 32'(o_div_busy), 32'd1);
        check("div1_wb_res", 32'(o_wb_reserved), 32'h0800);
        offer(OP_DIV, 6'd6);
        #1 check("div2_blocked_first", 32'(o_take), 32'd0);
        for (int i = 2; i <= 11; i++) begin
            @(negedge clk);
            check($sformatf("div_busy_c%0d", i), 32'(o_div_busy), 32'd1);
            #1 check($sformatf("div2_blocked_c%0d", i), 32'(o_take), 32'd0);
        end
        @(negedge clk);
        check("div_busy_release", 32'(o_div_busy), 32'd0);
        check("div1_wb_res_last", 32'(o_wb_reserved), 32'h0001);
        #1 check("div2_take", 32'(o_take), 32'd1);
        @(negedge clk);
        check("div2_ex_entry", 32'(o_ex_entry), 32'(mk(OP_DIV, 6'd6)));
        check("div2_busy", 32'(o_div_busy), 32'd1);
        check("div2_wb_res", 32'(o_wb_reserved), 32'h0800);
        i_want_to_execute = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Flush three cycles after the DIV take, with a takeable ALU offered.
        i_flush = 1'b1;
        offer(OP_ALU, 6'd7);
        #1 check("flush_take", 32'(o_take), 32'd0);
        @(negedge clk);
        check("flush_ex_valid", 32'(o_ex_valid), 32'd0);
        check("flush_wb_res", 32'(o_wb_reserved), 32'h0000);
        check("flush_div_busy", 32'(o_div_busy), 32'd0);
        i_flush = 1'b0;
        offer(OP_DIV, 6'd8);
        #1 check("post_flush_div_take", 32'(o_take), 32'd1);
        @(negedge clk);
        check("div3_ex_entry", 32'(o_ex_entry), 32'(mk(OP_DIV, 6'd8)));
        check("div3_busy", 32'(o_div_busy), 32'd1);

        // Reset mid-DIV with a takeable ALU offer.
        rst = 1'b1;
        offer(OP_ALU, 6'd9);
        #1 check("mid_reset_take", 32'(o_take), 32'd0);
        @(negedge clk);
        check_reset_state("mid_reset");
        rst = 1'b0;
        i_want_to_execute = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
